// File: rtl/aes_pkg.sv
// Shared AES constants and byte-substitution helpers for the AES-192 key schedule,
// used by both the forward expansion and the tail-key unroller.
package aes_pkg;

  localparam int unsigned NK     = 6;
  localparam int unsigned NR     = 12;
  localparam int unsigned NWORDS = 52;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:7][7:0] RCON = 64'h01020408_10204080;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // Rcon word for k in 1..8; any other index yields zero.
  function automatic logic [31:0] rcon_word(input logic [3:0] k);
    if (k >= 4'd1 && k <= 4'd8) return {RCON[3'(k - 4'd1)], 24'h0};
    return 32'h0;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_unroll192_pkg.sv
// Widths and FSM state encoding for the AES-192 reverse key-schedule unit.
package key_unroll192_pkg;
  import aes_pkg::*;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned RK_W   = 4 * WORD_W;
  localparam int unsigned TAIL_W = NK * WORD_W;
  localparam int unsigned J_W    = 6;
  localparam int unsigned RND_W  = 4;

  typedef enum logic [1:0] {IDLE, EMIT, STEP, FIN} state_e;

endpackage

// File: rtl/key_unroll192_if.sv
// Load / round-key / result bundle of key_unroll192.
interface key_unroll192_if;
  import key_unroll192_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [TAIL_W-1:0] tail_key;
  logic              rk_valid;
  logic              rk_ready;
  logic [RK_W-1:0]   rk;
  logic [RND_W-1:0]  rk_round;
  logic [TAIL_W-1:0] key_out;
  logic              done;

  modport master (
    output in_valid, tail_key, rk_ready,
    input  in_ready, rk_valid, rk, rk_round, key_out, done
  );

  modport slave (
    input  in_valid, tail_key, rk_ready,
    output in_ready, rk_valid, rk, rk_round, key_out, done
  );

endinterface

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout_c
);

  assign dout_c = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};

endmodule

// File: rtl/key_unroll192.sv
// Walks the AES-192 key schedule backwards from w[46..51], presenting round
// keys 12..0 and finally the recovered cipher key w[0..5].
module key_unroll192
  import aes_pkg::*;
  import key_unroll192_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  key_unroll192_if.slave bus
);

  localparam logic [J_W-1:0] J_INIT = J_W'(NWORDS - NK);

  state_e              state_q, state_d;
  logic [TAIL_W-1:0]   win_q, win_d, key_out_q, key_out_d, win_shift;
  logic [J_W-1:0]      j_q, j_d, i_w, j_dec, j_tgt;
  logic [RK_W-1:0]     rk_q, rk_d;
  logic [RND_W-1:0]    rk_round_q, rk_round_d;
  logic                rk_valid_q, rk_valid_d, done_q, done_d, in_ready_q, in_ready_d;
  logic [WORD_W-1:0]   w4, w5, sub_c, new_word;

  // Window slots W[4], W[5] are w[i-1], w[i] with i = j+5.
  assign w4    = win_q[63:32];
  assign w5    = win_q[31:0];
  assign i_w   = j_q + J_W'(5);
  assign j_dec = j_q - J_W'(1);
  assign j_tgt = {rk_round_q - RND_W'(1), 2'b00};

  aes_subword u_subword (
    .din    (rot_word(w4)),
    .dout_c (sub_c)
  );

  assign new_word  = (i_w % J_W'(NK) == '0)
                   ? (w5 ^ sub_c ^ rcon_word(RND_W'(i_w / J_W'(NK))))
                   : (w5 ^ w4);
  assign win_shift = {new_word, win_q[TAIL_W-1:WORD_W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= '0;
      j_q        <= J_INIT;
      rk_q       <= '0;
      rk_round_q <= '0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
      key_out_q  <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      j_q        <= j_d;
      rk_q       <= rk_d;
      rk_round_q <= rk_round_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
      key_out_q  <= key_out_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    j_d        = j_q;
    rk_d       = rk_q;
    rk_round_d = rk_round_q;
    rk_valid_d = rk_valid_q;
    done_d     = done_q;
    key_out_d  = key_out_q;
    case (state_q)
      IDLE, FIN: begin
        // Round 12 is the upper four words of the freshly loaded window.
        if (bus.in_valid) begin
          state_d    = EMIT;
          win_d      = bus.tail_key;
          j_d        = J_INIT;
          rk_d       = bus.tail_key[RK_W-1:0];
          rk_round_d = RND_W'(NR);
          rk_valid_d = 1'b1;
          done_d     = 1'b0;
        end
      end
      EMIT: begin
        if (bus.rk_ready) begin
          rk_valid_d = 1'b0;
          if (rk_round_q == '0) begin
            state_d   = FIN;
            done_d    = 1'b1;
            key_out_d = win_q;
          end else begin
            state_d = STEP;
          end
        end
      end
      STEP: begin
        win_d = win_shift;
        j_d   = j_dec;
        if (j_dec == j_tgt) begin
          state_d    = EMIT;
          rk_d       = win_shift[TAIL_W-1 -: RK_W];
          rk_round_d = rk_round_q - RND_W'(1);
          rk_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE) || (state_d == FIN);
  end

  assign bus.in_ready = in_ready_q;
  assign bus.rk_valid = rk_valid_q;
  assign bus.rk       = rk_q;
  assign bus.rk_round = rk_round_q;
  assign bus.key_out  = key_out_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_key_unroll192.sv
// Directed bench for key_unroll192 using an independent GF(2^8)-derived S-box
// and forward/backward AES-192 schedule models.
module tb_key_unroll192;

  typedef logic [127:0] beats_t [13];

  localparam logic [191:0] KEY_A = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [7:0] sb [256];

  key_unroll192_if bus ();

  key_unroll192 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h0;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? (8'(a << 1) ^ 8'h1b) : 8'(a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // S-box = affine transform of the multiplicative inverse.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sb[r[31:24]], sb[r[23:16]], sb[r[15:8]], sb[r[7:0]]};
  endfunction

  function automatic logic [31:0] rcon_ref(input int k);
    logic [7:0] r;
    r = 8'h01;
    for (int n = 1; n < k; n++) r = gmul(r, 8'h02);
    return {r, 24'h0};
  endfunction

  task automatic expand_fwd(input logic [191:0] key, output beats_t bt, output logic [191:0] tail);
    logic [31:0] w [52];
    logic [31:0] t;
    for (int i = 0; i < 6; i++) w[i] = key[191 - 32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) t = sub_rot(t) ^ rcon_ref(i / 6);
      w[i] = w[i-6] ^ t;
    end
    for (int b = 0; b < 13; b++) bt[b] = {w[4*(12-b)], w[4*(12-b)+1], w[4*(12-b)+2], w[4*(12-b)+3]};
    tail = {w[46], w[47], w[48], w[49], w[50], w[51]};
  endtask

  task automatic expand_bwd(input logic [191:0] tail, output beats_t bt, output logic [191:0] key);
    logic [31:0] w [52];
    logic [31:0] t;
    for (int i = 0; i < 6; i++) w[46+i] = tail[191 - 32*i -: 32];
    for (int i = 51; i >= 6; i--) begin
      t = w[i-1];
      if (i % 6 == 0) t = sub_rot(t) ^ rcon_ref(i / 6);
      w[i-6] = w[i] ^ t;
    end
    for (int b = 0; b < 13; b++) bt[b] = {w[4*(12-b)], w[4*(12-b)+1], w[4*(12-b)+2], w[4*(12-b)+3]};
    key = {w[0], w[1], w[2], w[3], w[4], w[5]};
  endtask

  task automatic load_key(input logic [191:0] t);
    @(negedge clk);
    bus.tail_key = t;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Samples at negedge; cycle 1 is the load cycle. Stalled beats must hold.
  task automatic collect(input beats_t exp, input logic [191:0] exp_key, input bit bp,
                         input bit poke, output beats_t got, output int done_cyc);
    int beat;
    bit stall;
    logic [127:0] h_rk;
    logic [3:0] h_rnd;
    beat = 0; stall = 1'b0; done_cyc = 0; h_rk = '0; h_rnd = '0;
    for (int n = 1; n <= 400 && done_cyc == 0; n++) begin
      @(negedge clk);
      if (n == 1) chk("done_clr", 192'(bus.done), 192'(0));
      if (stall) begin
        chk("hold_vld", 192'(bus.rk_valid), 192'(1));
        chk("hold_rk", 192'(bus.rk), 192'(h_rk));
        chk("hold_rnd", 192'(bus.rk_round), 192'(h_rnd));
      end
      if (bus.done) begin
        done_cyc = n;
        chk("key_out", bus.key_out, exp_key);
      end
      bus.in_valid = poke && n <= 3;
      if (poke) bus.tail_key = 192'h0123456789abcdeffedcba9876543210deadbeefcafef00d;
      bus.rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && n == 1) bus.rk_ready = 1'b0;
      if (bus.rk_valid && bus.rk_ready) begin
        if (beat < 13) begin
          got[beat] = bus.rk;
          chk("rk_beat", 192'(bus.rk), 192'(exp[beat]));
          chk("rk_round", 192'(bus.rk_round), 192'(12 - beat));
        end
        beat++;
      end
      stall = bus.rk_valid && !bus.rk_ready;
      h_rk  = bus.rk;
      h_rnd = bus.rk_round;
    end
    bus.in_valid = 1'b0;
    chk("beats", 192'(beat), 192'(13));
    if (done_cyc == 0) chk("done_timeout", 192'(0), 192'(1));
  endtask

  initial begin
    beats_t exp_a, exp_z, got;
    logic [191:0] tail_a, key_z;
    int dc, pulses;
    bit found;
    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.rk_ready = 1'b0;
    bus.tail_key = '0;
    build_sbox();
    expand_fwd(KEY_A, exp_a, tail_a);
    expand_bwd(192'h0, exp_z, key_z);

    repeat (3) @(negedge clk);
    chk("rst_valid", 192'(bus.rk_valid), 192'(0));
    chk("rst_rk", 192'(bus.rk), 192'(0));
    chk("rst_round", 192'(bus.rk_round), 192'(0));
    chk("rst_done", 192'(bus.done), 192'(0));
    chk("rst_key", bus.key_out, 192'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 192'(bus.in_ready), 192'(1));

    // FIPS-197 A.2 tail with the consumer always ready.
    load_key(tail_a);
    chk("busy_ready", 192'(bus.in_ready), 192'(0));
    collect(exp_a, KEY_A, 1'b0, 1'b0, got, dc);
    chk("first_rk", 192'(got[0]), 192'(128'he98ba06f448c773c8ecc720401002202));
    chk("round1_rk", 192'(got[11]), 192'(128'h62f8ead2522c6b7bfe0c91f72402f5a5));
    chk("last_rk", 192'(got[12]), 192'(128'h8e73b0f7da0e6452c810f32b809079e5));
    chk("done_cycle", 192'(dc), 192'(60));
    chk("fin_ready", 192'(bus.in_ready), 192'(1));

    // Random backpressure.
    load_key(tail_a);
    collect(exp_a, KEY_A, 1'b1, 1'b0, got, dc);

    // Stray in_valid while busy, then a load straight out of FIN.
    load_key(tail_a);
    collect(exp_a, KEY_A, 1'b0, 1'b1, got, dc);
    load_key(192'h0);
    chk("fin_load_rk", 192'(bus.rk), 192'(0));
    chk("fin_load_rnd", 192'(bus.rk_round), 192'(12));
    collect(exp_z, key_z, 1'b0, 1'b0, got, dc);

    // Reset in the STEP cycles between rounds 7 and 6.
    load_key(tail_a);
    bus.rk_ready = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (bus.rk_valid && bus.rk_round == 4'd7) found = 1'b1;
    end
    chk("find_r7", 192'(found), 192'(1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_valid", 192'(bus.rk_valid), 192'(0));
    chk("mid_rk", 192'(bus.rk), 192'(0));
    chk("mid_round", 192'(bus.rk_round), 192'(0));
    chk("mid_key", bus.key_out, 192'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rk_valid) pulses++;
    end
    chk("no_pulse", 192'(pulses), 192'(0));
    chk("post_ready", 192'(bus.in_ready), 192'(1));
    load_key(192'h0);
    chk("zero_r12", 192'(bus.rk), 192'(0));
    collect(exp_z, key_z, 1'b0, 1'b0, got, dc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
